// File: rtl/msg_gather_if.sv
// Stream-in / group-out bundle for msg_gather.
// master = feeder + min-stage side, slave = msg_gather itself.
interface msg_gather_if #(
    parameter int MSG_W = 11
);
    logic [MSG_W-1:0] in_msg;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [MSG_W-1:0] msg_1;
    logic [MSG_W-1:0] msg_2;
    logic [MSG_W-1:0] msg_3;
    logic [MSG_W-1:0] msg_4;
    logic [MSG_W-1:0] msg_5;
    logic             grp_valid;
    logic             grp_ready;
    logic             grp_err;

    modport master (
        output in_msg, in_valid, in_last, grp_ready,
        input  in_ready, msg_1, msg_2, msg_3, msg_4, msg_5, grp_valid, grp_err
    );

    modport slave (
        input  in_msg, in_valid, in_last, grp_ready,
        output in_ready, msg_1, msg_2, msg_3, msg_4, msg_5, grp_valid, grp_err
    );
endinterface

// File: rtl/msg_gather.sv
// Gathers variable-node messages into groups of five for the check-node min stage,
// double-buffered so one group can be presented while the next is assembled.
module msg_gather #(
    parameter int               MSG_W   = 11,
    parameter logic [MSG_W-1:0] PAD_VAL = {MSG_W{1'b1}}
) (
    input  logic         clk,
    input  logic         rst_n,
    msg_gather_if.slave  bus
);
    localparam int NSLOT = 5;

    logic [1:0][NSLOT-1:0][MSG_W-1:0] r_buf;
    logic [1:0]                       r_err;
    logic [1:0]                       r_fill;
    logic [2:0]                       r_slot;
    logic                             r_wr_sel;
    logic                             r_rd_sel;

    logic w_in_ready;
    logic w_acc;
    logic w_commit;
    logic w_pop;

    assign w_in_ready = (r_fill != 2'd2);
    assign w_acc      = bus.in_valid & w_in_ready;
    assign w_commit   = w_acc & (bus.in_last | (r_slot == 3'd4));
    assign w_pop      = (r_fill != 2'd0) & bus.grp_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf    <= '0;
            r_err    <= '0;
            r_fill   <= '0;
            r_slot   <= '0;
            r_wr_sel <= 1'b0;
            r_rd_sel <= 1'b0;
        end else begin
            if (w_acc) begin
                r_buf[r_wr_sel][r_slot] <= bus.in_msg;
                if (w_commit) begin
                    // Early in_last: fill the tail with the min-neutral value.
                    for (int s = 0; s < NSLOT; s++) begin
                        if (3'(s) > r_slot) r_buf[r_wr_sel][s] <= PAD_VAL;
                    end
                    r_err[r_wr_sel] <= ~(bus.in_last & (r_slot == 3'd4));
                    r_wr_sel        <= ~r_wr_sel;
                    r_slot          <= '0;
                end else begin
                    r_slot <= r_slot + 3'd1;
                end
            end
            if (w_pop) r_rd_sel <= ~r_rd_sel;
            if (w_commit && !w_pop)      r_fill <= r_fill + 2'd1;
            else if (!w_commit && w_pop) r_fill <= r_fill - 2'd1;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.grp_valid = (r_fill != 2'd0);
    assign bus.grp_err   = r_err[r_rd_sel];
    assign bus.msg_1     = r_buf[r_rd_sel][0];
    assign bus.msg_2     = r_buf[r_rd_sel][1];
    assign bus.msg_3     = r_buf[r_rd_sel][2];
    assign bus.msg_4     = r_buf[r_rd_sel][3];
    assign bus.msg_5     = r_buf[r_rd_sel][4];
endmodule

// File: tb/tb_msg_gather.sv
// Bench for msg_gather: a queue-of-groups model checked every cycle, plus directed literal checks.
module tb_msg_gather;
    localparam int         W   = 11;
    localparam logic [W-1:0] PAD = 11'h7FF;

    typedef struct packed {
        logic [4:0][W-1:0] m;
        logic              err;
    } grp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    msg_gather_if #(.MSG_W(W)) bus ();

    msg_gather #(.MSG_W(W), .PAD_VAL(PAD)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    bit   cmp_en = 0;
    grp_t q[$];
    logic [4:0][W-1:0] part;
    int   pslot;
    bit   last_acc;

    logic [W-1:0] basic[5] = '{11'h0A7, 11'h2BA, 11'h0A8, 11'h0B2, 11'h0A9};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h", nm, act, exp);
        end
    endtask

    function automatic logic [5*W-1:0] dut_msgs();
        return {bus.msg_5, bus.msg_4, bus.msg_3, bus.msg_2, bus.msg_1};
    endfunction

    function automatic logic [W-1:0] dut_min();
        logic [W-1:0] mn;
        mn = bus.msg_1;
        if (bus.msg_2 < mn) mn = bus.msg_2;
        if (bus.msg_3 < mn) mn = bus.msg_3;
        if (bus.msg_4 < mn) mn = bus.msg_4;
        if (bus.msg_5 < mn) mn = bus.msg_5;
        return mn;
    endfunction

    task automatic model_reset();
        q.delete();
        pslot = 0;
        part  = '0;
    endtask

    // One clock edge of the reference: fill = number of queued groups.
    task automatic model_step(input bit v, input logic [W-1:0] m, input bit l, input bit gr);
        bit   acc;
        bit   pop;
        grp_t g;
        acc = v && (q.size() < 2);
        pop = (q.size() > 0) && gr;
        last_acc = acc;
        if (pop) void'(q.pop_front());
        if (acc) begin
            part[pslot] = m;
            pslot++;
            if (l || pslot == 5) begin
                for (int s = pslot; s < 5; s++) part[s] = PAD;
                g.m   = part;
                g.err = !(l && pslot == 5);
                q.push_back(g);
                pslot = 0;
            end
        end
    endtask

    task automatic drive(input bit v, input logic [W-1:0] m, input bit l, input bit gr);
        bus.in_valid  = v;
        bus.in_msg    = m;
        bus.in_last   = l;
        bus.grp_ready = gr;
        @(posedge clk);
        model_step(v, m, l, gr);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("in_ready", bus.in_ready, q.size() < 2);
            chk("grp_valid", bus.grp_valid, q.size() > 0);
            if (q.size() > 0) begin
                chk("grp_msgs", dut_msgs(), q[0].m);
                chk("grp_err", bus.grp_err, q[0].err);
            end
        end
    end

    initial begin
        int k;
        int pops;
        bit seen;
        bus.in_valid = 0; bus.in_msg = '0; bus.in_last = 0; bus.grp_ready = 0;
        model_reset();

        #3;
        chk("rst_grp_valid", bus.grp_valid, 0);
        chk("rst_grp_err", bus.grp_err, 0);
        chk("rst_msgs", dut_msgs(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        cmp_en = 1;

        // basic full group
        for (int i = 0; i < 5; i++) drive(1, basic[i], i == 4, 1);
        chk("basic_valid", bus.grp_valid, 1);
        chk("basic_msgs", dut_msgs(), {11'h0A9, 11'h0B2, 11'h0A8, 11'h2BA, 11'h0A7});
        chk("basic_err", bus.grp_err, 0);
        chk("basic_min", dut_min(), 11'h0A7);
        drive(0, '0, 0, 1);

        // short group
        drive(1, 11'h010, 0, 0);
        drive(1, 11'h005, 0, 0);
        drive(1, 11'h020, 1, 0);
        chk("short_msg1", bus.msg_1, 11'h010);
        chk("short_msg4", bus.msg_4, 11'h7FF);
        chk("short_msg5", bus.msg_5, 11'h7FF);
        chk("short_err", bus.grp_err, 1);
        chk("short_min", dut_min(), 11'h005);
        drive(0, '0, 0, 1);

        // missing in_last: 7 messages
        for (int i = 0; i < 7; i++) drive(1, 11'(11'h100 + i), 0, 0);
        chk("ml_valid", bus.grp_valid, 1);
        chk("ml_err", bus.grp_err, 1);
        chk("ml_msg5", bus.msg_5, 11'h104);
        chk("ml_in_ready", bus.in_ready, 1);
        drive(0, '0, 0, 1);
        chk("ml_no_second", bus.grp_valid, 0);
        drive(1, 11'h107, 0, 0);
        drive(1, 11'h108, 0, 0);
        drive(1, 11'h109, 1, 0);
        chk("ml_tail_msgs", dut_msgs(), {11'h109, 11'h108, 11'h107, 11'h106, 11'h105});
        chk("ml_tail_err", bus.grp_err, 0);
        drive(0, '0, 0, 1);

        // backpressure: 15 messages, downstream stalled
        k = 0; seen = 0;
        for (int c = 0; c < 13; c++) begin
            drive(1, 11'(11'h200 + k), 0, 0);
            if (last_acc) k++;
            if (k == 10 && !seen) begin
                seen = 1;
                chk("bp_full_rdy", bus.in_ready, 0);
            end
        end
        chk("bp_hold_msg1", bus.msg_1, 11'h200);
        chk("bp_hold_msg5", bus.msg_5, 11'h204);
        drive(1, 11'(11'h200 + k), 0, 1);
        chk("bp_reopen_rdy", bus.in_ready, 1);
        chk("bp_second_msg1", bus.msg_1, 11'h205);
        for (int c = 0; c < 10 && k < 15; c++) begin
            drive(1, 11'(11'h200 + k), 0, 0);
            if (last_acc) k++;
        end
        repeat (3) drive(0, '0, 0, 1);
        chk("bp_drained", bus.grp_valid, 0);

        // continuous stream with downstream always ready
        pops = 0;
        for (int i = 0; i < 25; i++) begin
            drive(1, 11'($urandom), (i % 5) == 4, 1);
            chk("st_in_ready", bus.in_ready, 1);
            if (bus.grp_valid) pops++;
        end
        chk("st_groups", pops, 5);
        drive(0, '0, 0, 1);

        // async reset mid-group with a stored group pending
        for (int i = 0; i < 5; i++) drive(1, 11'(11'h300 + i), i == 4, 0);
        drive(1, 11'h310, 0, 0);
        drive(1, 11'h311, 0, 0);
        chk("mr_pre_valid", bus.grp_valid, 1);
        bus.in_valid = 0;
        #1 rst_n = 1'b0;
        #1;
        chk("mr_valid", bus.grp_valid, 0);
        chk("mr_msgs", dut_msgs(), 0);
        chk("mr_err", bus.grp_err, 0);
        model_reset();
        #1 rst_n = 1'b1;
        #1;
        chk("mr_in_ready", bus.in_ready, 1);
        for (int i = 0; i < 5; i++) drive(1, 11'(11'h320 + i), i == 4, 0);
        chk("mr_after_msgs", dut_msgs(), {11'h324, 11'h323, 11'h322, 11'h321, 11'h320});
        chk("mr_after_err", bus.grp_err, 0);
        drive(0, '0, 0, 1);

        // randomized traffic against the model
        for (int c = 0; c < 800; c++) begin
            drive($urandom_range(0, 3) != 0, 11'($urandom),
                  $urandom_range(0, 3) == 0, $urandom_range(0, 2) != 0);
        end
        repeat (4) drive(0, '0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
